f32_operand_loader: RTL and testbench
=====================================

# f32_operand_loader

Sequential front/back-end wrapper for the combinational float-32 adder/subtractor. It assembles operands A and B from an 8-bit data bus, one byte per load strobe, and latches the operation select. It then holds the operands stable for a programmable settle window and captures the adder's result and flags into registered outputs. It sits between board-level input logic (switches and a debounced key) and the display/readback logic, with the adder instanced beside it.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles the operands are held before the result is captured; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- DIN  in  8  operand byte to shift in.
- LOAD  in  1  single-cycle strobe, already synchronised and debounced; consumes DIN.
- OP_IN  in  1  operation select, 0 = add, 1 = sub; sampled on the 8th LOAD.
- CLEAR  in  1  synchronous abort/clear.
- A_OUT  out  32  operand A to the adder.
- B_OUT  out  32  operand B to the adder.
- OP_OUT  out  1  latched operation to the adder.
- R_IN  in  32  adder result.
- UF_IN, OF_IN  in  1 each  adder underflow and overflow flags.
- RESULT  out  32  captured result.
- UNDERFLOW_Q, OVERFLOW_Q  out  1 each  captured flags.
- BUSY  out  1  high while in SETTLE.
- DONE  out  1  high while in SHOW.
- BYTE_IDX  out  3  number of bytes loaded so far in the current entry (0..7).

## Operation
- States: LOAD_A, LOAD_B, SETTLE, SHOW. 4-bit settle counter CNT.
- Reset (RST_N low, asynchronous) sets:
  - state LOAD_A, BYTE_IDX 0, CNT 0;
  - A_OUT, B_OUT, RESULT all 0;
  - OP_OUT, UNDERFLOW_Q, OVERFLOW_Q, BUSY, DONE all 0.
- Bytes load MS byte first:
  - in LOAD_A: A_OUT <= {A_OUT[23:0], DIN};
  - in LOAD_B: B_OUT <= {B_OUT[23:0], DIN}.
- LOAD_A: each LOAD shifts into A and increments BYTE_IDX. The 4th LOAD (BYTE_IDX 3 -> 4) moves to LOAD_B.
- LOAD_B: each LOAD shifts into B and increments BYTE_IDX. The 8th LOAD does all of the following:
  - latches OP_OUT <= OP_IN;
  - sets CNT 0 and BYTE_IDX wraps to 0;
  - moves to SETTLE.
- SETTLE: LOAD is ignored and A_OUT/B_OUT/OP_OUT are frozen. CNT increments each cycle.
  - When CNT == SETTLE_CYCLES-1, the next edge captures RESULT <= R_IN, UNDERFLOW_Q <= UF_IN, OVERFLOW_Q <= OF_IN and moves to SHOW.
- SHOW: RESULT and flags are held. A LOAD starts a new entry:
  - A_OUT <= {24'h0, DIN}, B_OUT <= 0, BYTE_IDX 1, state LOAD_A.
  - RESULT and flags keep their values until the next capture.
- CLEAR, any state: forces the reset values on every register and output except RESULT/UNDERFLOW_Q/OVERFLOW_Q, which are also zeroed.
- CLEAR and LOAD in the same cycle: CLEAR wins and the byte is discarded.
- LOAD with no state change (SETTLE) is dropped. It is not queued.
- BUSY = (state == SETTLE). DONE = (state == SHOW). Both are decoded from registered state, with no combinational path from inputs.

## Timing
- The 8th LOAD sampled at edge k:
  - BUSY is high from k to k+SETTLE_CYCLES;
  - the capture happens at edge k+SETTLE_CYCLES;
  - DONE rises after that edge.
- With default 4: capture at k+4.
- The adder is combinational. SETTLE_CYCLES × clock period must exceed the adder's critical path. Operands are stable for the whole window.
- Minimum time from the first byte to DONE: 7 LOAD-separated cycles plus SETTLE_CYCLES + 1.
- Back-to-back LOADs on consecutive cycles are legal in LOAD_A/LOAD_B.
- Reset mid-SETTLE: immediate return to LOAD_A. No capture occurs.

## Test plan
- Reset, then 8 LOADs (3F,80,00,00,40,00,00,00) with OP_IN=0. Expect A_OUT=3F800000, B_OUT=40000000, OP_OUT=0, BUSY for 4 cycles. Bench drives R_IN=40400000, so RESULT=40400000 and DONE=1 exactly at edge k+4.
- Same bytes with OP_IN=1 and R_IN=BF800000, UF_IN=1. Expect RESULT=BF800000, UNDERFLOW_Q=1, OVERFLOW_Q=0.
- In SETTLE, pulse LOAD with DIN=FF and change R_IN until one cycle before capture. Expect A_OUT/B_OUT unchanged, BYTE_IDX=0, captured value equals R_IN at the capture edge only.
- After 5 LOADs assert CLEAR together with a LOAD. Expect A_OUT=B_OUT=0, BYTE_IDX=0, LOAD_A, and the next 8 bytes load cleanly.
- In SHOW, LOAD DIN=12. Expect A_OUT=00000012, B_OUT=0, BYTE_IDX=1, DONE=0, RESULT held.
- Drop RST_N asynchronously between edges during SETTLE. Expect all outputs 0 immediately, no capture, and SETTLE_CYCLES=1 build captures at k+1.

Source files
------------

// File: rtl/f32_operand_loader.sv
// Operand loader for the float-32 adder: shifts A and B in a byte at a time,
// holds them for a settle window, then captures the adder result and flags.
module f32_operand_loader #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  DIN,
    input  logic        LOAD,
    input  logic        OP_IN,
    input  logic        CLEAR,
    output logic [31:0] A_OUT,
    output logic [31:0] B_OUT,
    output logic        OP_OUT,
    input  logic [31:0] R_IN,
    input  logic        UF_IN,
    input  logic        OF_IN,
    output logic [31:0] RESULT,
    output logic        UNDERFLOW_Q,
    output logic        OVERFLOW_Q,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  BYTE_IDX
);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, SHOW} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  byteIdx_q, byteIdx_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        uf_q, uf_d;
    logic        of_q, of_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= LOAD_A;
            cnt_q     <= '0;
            byteIdx_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            result_q  <= '0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byteIdx_q <= byteIdx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            uf_q      <= uf_d;
            of_q      <= of_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byteIdx_d = byteIdx_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        uf_d      = uf_q;
        of_d      = of_q;

        // CLEAR outranks everything, including a LOAD in the same cycle.
        if (CLEAR) begin
            state_d   = LOAD_A;
            cnt_d     = '0;
            byteIdx_d = '0;
            a_d       = '0;
            b_d       = '0;
            op_d      = 1'b0;
            result_d  = '0;
            uf_d      = 1'b0;
            of_d      = 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (LOAD) begin
                        a_d       = {a_q[23:0], DIN};
                        byteIdx_d = byteIdx_q + 3'd1;
                        if (byteIdx_q == 3'd3) begin
                            state_d = LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (LOAD) begin
                        b_d       = {b_q[23:0], DIN};
                        byteIdx_d = byteIdx_q + 3'd1;
                        if (byteIdx_q == 3'd7) begin
                            op_d    = OP_IN;
                            cnt_d   = '0;
                            state_d = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = R_IN;
                        uf_d     = UF_IN;
                        of_d     = OF_IN;
                        cnt_d    = '0;
                        state_d  = SHOW;
                    end
                end
                SHOW: begin
                    if (LOAD) begin
                        a_d       = {24'h0, DIN};
                        b_d       = '0;
                        byteIdx_d = 3'd1;
                        state_d   = LOAD_A;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    assign A_OUT       = a_q;
    assign B_OUT       = b_q;
    assign OP_OUT      = op_q;
    assign RESULT      = result_q;
    assign UNDERFLOW_Q = uf_q;
    assign OVERFLOW_Q  = of_q;
    assign BYTE_IDX    = byteIdx_q;
    assign BUSY        = (state_q == SETTLE);
    assign DONE        = (state_q == SHOW);

endmodule

// File: tb/tb_f32_operand_loader.sv
// Self-checking bench for f32_operand_loader: directed scenarios plus random
// traffic, all compared against a behavioural model of the loader.
module tb_f32_operand_loader;

    localparam int SET = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  din;
    logic        load, opIn, clear;
    logic [31:0] rIn;
    logic        ufIn, ofIn;
    logic [31:0] aOut, bOut, result;
    logic        opOut, underflowQ, overflowQ, busy, done;
    logic [2:0]  byteIdx;

    // Second instance built with a one-cycle settle window.
    logic [7:0]  din1;
    logic        load1;
    logic [31:0] rIn1;
    logic [31:0] aOut1, bOut1, result1;
    logic        opOut1, underflowQ1, overflowQ1, busy1, done1;
    logic [2:0]  byteIdx1;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = entering bytes, 1 = settling, 2 = showing.
    logic [31:0] mA, mB, mRes;
    logic        mOp, mUf, mOf;
    int          mPhase, mCount, mLeft;

    always #5 clk = ~clk;

    f32_operand_loader #(.SETTLE_CYCLES(SET)) dut (
        .CLK(clk), .RST_N(rstN), .DIN(din), .LOAD(load), .OP_IN(opIn), .CLEAR(clear),
        .A_OUT(aOut), .B_OUT(bOut), .OP_OUT(opOut), .R_IN(rIn), .UF_IN(ufIn), .OF_IN(ofIn),
        .RESULT(result), .UNDERFLOW_Q(underflowQ), .OVERFLOW_Q(overflowQ),
        .BUSY(busy), .DONE(done), .BYTE_IDX(byteIdx)
    );

    f32_operand_loader #(.SETTLE_CYCLES(1)) dut1 (
        .CLK(clk), .RST_N(rstN), .DIN(din1), .LOAD(load1), .OP_IN(1'b0), .CLEAR(1'b0),
        .A_OUT(aOut1), .B_OUT(bOut1), .OP_OUT(opOut1), .R_IN(rIn1), .UF_IN(1'b0), .OF_IN(1'b0),
        .RESULT(result1), .UNDERFLOW_Q(underflowQ1), .OVERFLOW_Q(overflowQ1),
        .BUSY(busy1), .DONE(done1), .BYTE_IDX(byteIdx1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mA = '0; mB = '0; mRes = '0; mOp = 1'b0; mUf = 1'b0; mOf = 1'b0;
        mPhase = 0; mCount = 0; mLeft = 0;
    endtask

    task automatic modelEdge();
        if (clear) begin
            modelReset();
        end else if (mPhase == 0) begin
            if (load) begin
                if (mCount < 4) mA = mA * 256 + 32'(din);
                else            mB = mB * 256 + 32'(din);
                mCount++;
                if (mCount == 8) begin
                    mOp = opIn; mCount = 0; mPhase = 1; mLeft = SET;
                end
            end
        end else if (mPhase == 1) begin
            mLeft--;
            if (mLeft == 0) begin
                mRes = rIn; mUf = ufIn; mOf = ofIn; mPhase = 2;
            end
        end else if (load) begin
            mA = 32'(din); mB = '0; mCount = 1; mPhase = 0;
        end
    endtask

    task automatic compareAll();
        checkOutput("A_OUT", aOut, mA);
        checkOutput("B_OUT", bOut, mB);
        checkOutput("OP_OUT", 32'(opOut), 32'(mOp));
        checkOutput("RESULT", result, mRes);
        checkOutput("UNDERFLOW_Q", 32'(underflowQ), 32'(mUf));
        checkOutput("OVERFLOW_Q", 32'(overflowQ), 32'(mOf));
        checkOutput("BUSY", 32'(busy), 32'(mPhase == 1));
        checkOutput("DONE", 32'(done), 32'(mPhase == 2));
        checkOutput("BYTE_IDX", 32'(byteIdx), 32'(mCount));
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit later.
    task automatic applyStimulus(input logic ld, input logic [7:0] d, input logic op, input logic clr);
        load = ld; din = d; opIn = op; clear = clr;
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic loadBytes(input logic [63:0] bytes, input logic op);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, bytes[63 - 8*i -: 8], op, 1'b0);
        end
    endtask

    initial begin
        rstN = 1'b0; din = '0; load = 1'b0; opIn = 1'b0; clear = 1'b0;
        rIn = '0; ufIn = 1'b0; ofIn = 1'b0;
        din1 = '0; load1 = 1'b0; rIn1 = '0;
        modelReset();
        #12;
        compareAll();
        checkOutput("reset A_OUT", aOut, 32'h0);
        checkOutput("reset DONE", 32'(done), 32'h0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Add case: 1.0 + 2.0 with the adder answer held at 3.0.
        rIn = 32'h40400000;
        loadBytes(64'h3F800000_40000000, 1'b0);
        checkOutput("add A_OUT", aOut, 32'h3F800000);
        checkOutput("add B_OUT", bOut, 32'h40000000);
        checkOutput("add BUSY at k", 32'(busy), 32'h1);
        for (int i = 1; i < SET; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("add BUSY held", 32'(busy), 32'h1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("add DONE at k+4", 32'(done), 32'h1);
        checkOutput("add RESULT", result, 32'h40400000);

        // Subtract case with underflow flagged; SHOW -> new entry starts it.
        applyStimulus(1'b1, 8'h3F, 1'b0, 1'b0);
        rIn = 32'hBF800000; ufIn = 1'b1;
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, (i < 4) ? ((i == 1) ? 8'h80 : 8'h00) : ((i == 4) ? 8'h40 : 8'h00), 1'b1, 1'b0);
        end
        checkOutput("sub OP_OUT", 32'(opOut), 32'h1);
        repeat (SET) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("sub RESULT", result, 32'hBF800000);
        checkOutput("sub UNDERFLOW_Q", 32'(underflowQ), 32'h1);
        checkOutput("sub OVERFLOW_Q", 32'(overflowQ), 32'h0);
        ufIn = 1'b0;

        // SHOW: LOAD of 0x12 starts a fresh entry, RESULT kept.
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        checkOutput("show A_OUT", aOut, 32'h00000012);
        checkOutput("show BYTE_IDX", 32'(byteIdx), 32'h1);
        checkOutput("show RESULT held", result, 32'hBF800000);

        // Finish the entry, then hammer LOAD and wiggle R_IN during SETTLE.
        for (int i = 1; i < 8; i++) applyStimulus(1'b1, 8'(i * 17), 1'b0, 1'b0);
        for (int i = 0; i < SET; i++) begin
            rIn = $urandom;
            applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        end
        checkOutput("settle BYTE_IDX", 32'(byteIdx), 32'h0);

        // CLEAR together with a LOAD after five bytes.
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        checkOutput("clear A_OUT", aOut, 32'h0);
        checkOutput("clear B_OUT", bOut, 32'h0);
        checkOutput("clear BYTE_IDX", 32'(byteIdx), 32'h0);
        loadBytes(64'h01234567_89ABCDEF, 1'b0);
        checkOutput("reload A_OUT", aOut, 32'h01234567);
        checkOutput("reload B_OUT", bOut, 32'h89ABCDEF);

        // Asynchronous reset between edges in the middle of SETTLE.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rstN = 1'b0;
        #1;
        modelReset();
        compareAll();
        checkOutput("async rst BUSY", 32'(busy), 32'h0);
        #1 rstN = 1'b1;
        repeat (SET + 1) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("async rst no capture", result, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            rIn = $urandom; ufIn = 1'($urandom); ofIn = 1'($urandom);
            applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);
        end

        // One-cycle settle build captures on the edge after the 8th LOAD.
        rIn1 = 32'hC0A00000;
        for (int i = 0; i < 8; i++) begin
            load1 = 1'b1; din1 = 8'(i + 1);
            @(posedge clk); #1;
        end
        load1 = 1'b0;
        checkOutput("S1 BUSY at k", 32'(busy1), 32'h1);
        checkOutput("S1 B_OUT", bOut1, 32'h05060708);
        @(posedge clk); #1;
        checkOutput("S1 DONE at k+1", 32'(done1), 32'h1);
        checkOutput("S1 RESULT", result1, 32'hC0A00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
